// File: rtl/btn_press_counter.sv
// btn_press_counter
// Debounced push-button event counter for the seven-segment display path.
// The raw active-low button is synchronized, filtered by a four-state
// debounce FSM, and turned into a one-cycle press strobe. The 16-bit display
// count advances once per strobe and can be cleared synchronously.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   When defined, holding the button issues extra strobes: the first one
//   REPEAT_DELAY cycles after the press is accepted, then one every
//   REPEAT_PERIOD cycles while the button stays held.
//   When undefined, there is exactly one strobe per accepted press, and the
//   repeat timer and its parameters do not exist.
module btn_press_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic        clr,
  output logic        pressed,
  output logic        press_pulse,
  output logic [15:0] count
);

  // Debounce timer: counts 0..DEBOUNCE_CYCLES-1, so $clog2 bits always fit.
  localparam int unsigned    TW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_REL       = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } state_e;

  // Synchronizer stages; both idle at the released level (1).
  logic          s1_q;
  logic          s2_q;

  // Debounce FSM state and its registered outputs.
  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          pressed_q;
  logic          press_pulse_q;

  // Display count.
  logic [15:0]   count_q;
  logic [15:0]   count_d;

  // Strobe sources decoded from the current state.
  logic          timer_done_s;
  logic          press_accept_s;
  logic          repeat_fire_s;
  logic          pulse_fire_s;

  // Two-flop synchronizer on the asynchronous button; only s2_q is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end

  assign timer_done_s   = (timer_q == TIMER_LAST);
  assign press_accept_s = (state_q == ST_PRESS_CHK) && !s2_q && timer_done_s;

`ifdef BTN_AUTO_REPEAT_EN
  // Repeat timer: long enough for whichever of delay/period is larger.
  localparam int unsigned    RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned    RW       = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RW-1:0] RPT_ZERO = RW'(0);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);
  localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_q;
  logic [RW-1:0] rpt_cnt_d;
  // Set once the first (delayed) repeat has fired; later repeats use the period.
  logic          rpt_armed_q;
  logic          rpt_armed_d;
  logic          rpt_fire_s;
  logic [RW-1:0] rpt_limit_s;

  assign rpt_limit_s = rpt_armed_q ? RPT_PER_LAST : RPT_DLY_LAST;

  // Repeat timer next state: runs while held, freezes during release qualification, clears otherwise
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_fire_s  = 1'b0;
    if ((state_q == ST_HELD) && !s2_q) begin
      if (rpt_cnt_q == rpt_limit_s) begin
        rpt_fire_s  = 1'b1;
        rpt_cnt_d   = RPT_ZERO;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + RPT_ONE;
      end
    end else if ((state_q == ST_HELD) || (state_q == ST_REL_CHK)) begin
      // Leaving HELD or bouncing on release: keep the repeat phase intact.
      rpt_cnt_d   = rpt_cnt_q;
      rpt_armed_d = rpt_armed_q;
    end else begin
      // REL and PRESS_CHK: the next HELD entry starts a fresh delay.
      rpt_cnt_d   = RPT_ZERO;
      rpt_armed_d = 1'b0;
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= RPT_ZERO;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  assign repeat_fire_s = rpt_fire_s;
`else
  assign repeat_fire_s = 1'b0;
`endif

  // Strobe and count next state; clear wins over a simultaneous strobe
  always_comb begin
    pulse_fire_s = press_accept_s | repeat_fire_s;
    if (clr) begin
      count_d = 16'h0000;
    end else if (pulse_fire_s) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
  end

  // Debounce FSM with registered pressed level and press strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REL;
      timer_q       <= TIMER_ZERO;
      pressed_q     <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      press_pulse_q <= pulse_fire_s;
      case (state_q)
        ST_REL: begin
          timer_q <= TIMER_ZERO;
          if (!s2_q) begin
            state_q <= ST_PRESS_CHK;
          end else begin
            state_q <= ST_REL;
          end
        end
        ST_PRESS_CHK: begin
          if (s2_q) begin
            // Bounce before qualification: start over from released.
            state_q <= ST_REL;
            timer_q <= TIMER_ZERO;
          end else if (timer_done_s) begin
            state_q   <= ST_HELD;
            timer_q   <= TIMER_ZERO;
            pressed_q <= 1'b1;
          end else begin
            state_q <= ST_PRESS_CHK;
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        ST_HELD: begin
          timer_q <= TIMER_ZERO;
          if (s2_q) begin
            state_q <= ST_REL_CHK;
          end else begin
            state_q <= ST_HELD;
          end
        end
        ST_REL_CHK: begin
          if (!s2_q) begin
            // Bounce during release: still held.
            state_q <= ST_HELD;
            timer_q <= TIMER_ZERO;
          end else if (timer_done_s) begin
            state_q   <= ST_REL;
            timer_q   <= TIMER_ZERO;
            pressed_q <= 1'b0;
          end else begin
            state_q <= ST_REL_CHK;
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        default: begin
          state_q   <= ST_REL;
          timer_q   <= TIMER_ZERO;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  // Display count register, updated on the same edge the strobe is raised
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_pulse = press_pulse_q;
  assign count       = count_q;

endmodule

// File: tb/tb_btn_press_counter.sv
// Testbench for btn_press_counter. Expected strobes (edge number and count
// value) are queued when a press is driven and popped when the DUT strobes.
`timescale 1ns/1ps
module tb_btn_press_counter;

  localparam int unsigned DEB = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RDLY = 10;
  localparam int unsigned RPER = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic        clr;
  logic        pressed;
  logic        press_pulse;
  logic [15:0] count;

  int          cyc = 0;
  int          n_vec;
  int          n_err;
  logic [15:0] exp_cnt;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  btn_press_counter #(
    .DEBOUNCE_CYCLES(DEB)
`ifdef BTN_AUTO_REPEAT_EN
    , .REPEAT_DELAY(RDLY)
    , .REPEAT_PERIOD(RPER)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .clr         (clr),
    .pressed     (pressed),
    .press_pulse (press_pulse),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Edge counter: value after posedge N is N
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int c, input bit do_clr);
    exp_t e;
    if (do_clr) exp_cnt = 16'h0000;
    else        exp_cnt = exp_cnt + 16'h0001;
    e.cyc = 32'(c);
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Button goes low at the negedge after edge t0: accept at edge t0+1+DEB+2
  task automatic plan_pulses(input int t0, input int hold, input bit clr_hit);
    sb_push(t0 + int'(DEB) + 3, clr_hit);
`ifdef BTN_AUTO_REPEAT_EN
    begin
      int t_leave;
      int t;
      t_leave = t0 + hold + 3;
      t = t0 + int'(DEB) + 3 + int'(RDLY);
      while (t < t_leave) begin
        sb_push(t, 1'b0);
        t += int'(RPER);
      end
    end
`endif
  endtask

  task automatic track(input int t0, input int hold, input int gap, input bit acc, input bit clr_hit);
    int   t_acc;
    int   t_fall;
    logic exp_p;
    t_acc  = t0 + int'(DEB) + 3;
    t_fall = t0 + hold + int'(DEB) + 3;
    for (int i = 1; i <= hold + gap; i++) begin
      @(negedge clk);
      if (i == hold) btn = 1'b1;
      if (clr_hit && cyc == t_acc - 1) clr = 1'b1;
      if (clr_hit && cyc == t_acc + 1) begin
        clr = 1'b0;
        chk_eq("clr_next_cycle", 32'(count), 32'd0);
      end
      exp_p = acc && (cyc >= t_acc) && (cyc < t_fall);
      chk_eq("pressed", 32'(pressed), 32'(exp_p));
    end
    chk_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic press(input int hold, input int gap, input bit acc, input bit clr_hit);
    int t0;
    @(negedge clk);
    btn = 1'b0;
    t0  = cyc;
    if (acc) plan_pulses(t0, hold, clr_hit);
    track(t0, hold, gap, acc, clr_hit);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_cnt = 16'h0000;
    chk_eq("clr_count", 32'(count), 32'd0);
  endtask

  // Scoreboard monitor: every strobe must match the next queued expectation
  initial begin
    logic prev_p;
    exp_t e;
    prev_p = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_p) chk_eq("pulse_width", 32'(press_pulse), 32'd0);
      if (press_pulse) begin
        if (sb.size() == 0) begin
          chk_eq("unexp_pulse", 32'(press_pulse), 32'd0);
        end else begin
          e = sb.pop_front();
          chk_eq("pulse_edge", 32'(cyc), e.cyc);
          chk_eq("pulse_count", 32'(count), 32'(e.cnt));
          chk_eq("pulse_pressed", 32'(pressed), 32'd1);
        end
      end
      prev_p = press_pulse;
    end
  end

  initial begin
    int t0;
    n_vec   = 0;
    n_err   = 0;
    exp_cnt = 16'h0000;
    rst_n   = 1'b0;
    btn     = 1'b0;
    clr     = 1'b0;

    // Reset with the button held: outputs stay quiet
    repeat (3) begin
      @(negedge clk);
      chk_eq("rst_pressed", 32'(pressed), 32'd0);
      chk_eq("rst_pulse", 32'(press_pulse), 32'd0);
      chk_eq("rst_count", 32'(count), 32'd0);
    end

    // Release reset while held: press is re-qualified and strobes
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    plan_pulses(t0, 20, 1'b0);
    track(t0, 20, 20, 1'b1, 1'b0);
    chk_eq("count_after_reset", 32'(count), 32'(exp_cnt));

    // Short glitches never qualify
    do_clear();
    repeat (5) press(3, 5, 1'b0, 1'b0);
    chk_eq("glitch_count", 32'(count), 32'd0);

    // Ten clean presses
    repeat (10) press(20, 20, 1'b1, 1'b0);
    chk_eq("ten_presses", 32'(count), 32'(exp_cnt));

    // Clear coinciding with a strobe
    do_clear();
    repeat (7) press(20, 20, 1'b1, 1'b0);
    chk_eq("count_before_clr", 32'(count), 32'(exp_cnt));
    press(20, 20, 1'b1, 1'b1);
    chk_eq("count_after_clr", 32'(count), 32'(exp_cnt));

    // Wrap from 0xFFFF
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    chk_eq("preload", 32'(count), 32'h0000FFFF);
    press(20, 20, 1'b1, 1'b0);
    chk_eq("wrap_count", 32'(count), 32'(exp_cnt));

`ifdef BTN_AUTO_REPEAT_EN
    // Held 30 cycles past acceptance: accept plus five repeats
    do_clear();
    press(int'(DEB) + 3 + 30, 20, 1'b1, 1'b0);
    chk_eq("repeat_count", 32'(count), 32'd6);
`endif

    chk_eq("sb_final", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
